// File: rtl/wb_gpio_bridge.sv
// wb_gpio_bridge: Wishbone slave GPIO controller.
//
// Purpose: exposes up to 64 pad pins through a 256-byte register window.
// It provides output and output-enable registers, a 2-flop input
// synchroniser, per-pin rising/falling edge detection, sticky W1C
// interrupt status and a registered level interrupt. Pins set in
// RESERVED_MASK are always inputs, and their register bits stay 0.
//
// Register map (LO word = bits 31:0, HI word = bits 63:32):
//   0x00/0x04 OUT   rw
//   0x08/0x0C OE    rw, 1 = drive
//   0x10/0x14 IN    ro, synchronised pin state
//   0x18/0x1C IE    rw, edge interrupt enable
//   0x20/0x24 EDGE  rw, 1 = rising, 0 = falling
//   0x28/0x2C STAT  W1C sticky event status
//   Any other offset in the window is acked, reads 0 and ignores writes.
//
// Ports:
//   wb_clk_i   sole clock
//   wb_rst_i   synchronous active-high reset
//   wbs_*      Wishbone slave (cyc, stb, we, sel, adr, dat in; ack, dat out)
//   gpio_in    asynchronous pad inputs
//   gpio_out   pad output values
//   gpio_oeb   active-low pad output enables
//   irq        level interrupt, |(STAT & IE), registered
module wb_gpio_bridge #(
    parameter int unsigned NUM_GPIO      = 38,
    parameter logic [63:0] RESERVED_MASK = 64'h1E,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);

    // Bits that exist as pins, and the subset software may set.
    localparam logic [63:0] VALID_MASK = (NUM_GPIO >= 64) ? {64{1'b1}} :
                                         ((64'd1 << NUM_GPIO) - 64'd1);
    localparam logic [63:0] WR_MASK    = VALID_MASK & ~RESERVED_MASK;

    localparam logic [4:0] REG_OUT  = 5'd0;
    localparam logic [4:0] REG_OE   = 5'd1;
    localparam logic [4:0] REG_IN   = 5'd2;
    localparam logic [4:0] REG_IE   = 5'd3;
    localparam logic [4:0] REG_EDGE = 5'd4;
    localparam logic [4:0] REG_STAT = 5'd5;

    // Registers
    logic [63:0]         r_out;
    logic [63:0]         r_oe;
    logic [63:0]         r_ie;
    logic [63:0]         r_edge;
    logic [63:0]         r_stat;
    logic [NUM_GPIO-1:0] r_sync1;
    logic [NUM_GPIO-1:0] r_sync2;
    logic [NUM_GPIO-1:0] r_prev;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_irq;

    // Bus decode
    logic        w_hit;
    logic        w_acc;
    logic        w_wr;
    logic        w_hi;
    logic [4:0]  w_reg;
    logic [31:0] w_lane32;
    logic [63:0] w_lane;
    logic [63:0] w_wdat;
    logic        w_unused_adr;

    // Input path / events
    logic [63:0] w_in;
    logic [63:0] w_prev;
    logic [63:0] w_rise;
    logic [63:0] w_fall;
    logic [63:0] w_ev;
    logic [63:0] w_clr;

    // Next-state and read mux
    logic [63:0] w_out_d;
    logic [63:0] w_oe_d;
    logic [63:0] w_ie_d;
    logic [63:0] w_edge_d;
    logic [63:0] w_stat_d;
    logic [63:0] w_rd64;
    logic [31:0] w_rd32;

    // An access is taken only on a hit cycle that is not already acking,
    // so a held strobe gets one ack every second cycle.
    assign w_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_acc  = w_hit & ~r_ack;
    assign w_wr   = w_acc & wbs_we_i;
    assign w_hi   = wbs_adr_i[2];
    assign w_reg  = wbs_adr_i[7:3];

    // Word-aligned register file; the byte offset bits carry no meaning.
    assign w_unused_adr = ^wbs_adr_i[1:0];

    assign w_lane32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_lane   = w_hi ? {w_lane32, 32'h0} : {32'h0, w_lane32};
    assign w_wdat   = {wbs_dat_i, wbs_dat_i};

    assign w_in   = 64'(r_sync2);
    assign w_prev = 64'(r_prev);
    assign w_rise = w_in & ~w_prev;
    assign w_fall = ~w_in & w_prev;
    assign w_ev   = r_ie & ((r_edge & w_rise) | (~r_edge & w_fall));

    // W1C: only selected lanes written with 1 clear; a new event still sets.
    assign w_clr    = (w_wr && (w_reg == REG_STAT)) ? (w_lane & w_wdat) : 64'h0;
    assign w_stat_d = ((r_stat & ~w_clr) | w_ev) & WR_MASK;

    function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                                input logic [63:0] lane,
                                                input logic [63:0] data);
        return ((old_val & ~lane) | (data & lane)) & WR_MASK;
    endfunction

    always_comb begin
        w_out_d  = r_out;
        w_oe_d   = r_oe;
        w_ie_d   = r_ie;
        w_edge_d = r_edge;
        if (w_wr) begin
            case (w_reg)
                REG_OUT:  w_out_d  = merge_lanes(r_out, w_lane, w_wdat);
                REG_OE:   w_oe_d   = merge_lanes(r_oe, w_lane, w_wdat);
                REG_IE:   w_ie_d   = merge_lanes(r_ie, w_lane, w_wdat);
                REG_EDGE: w_edge_d = merge_lanes(r_edge, w_lane, w_wdat);
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_rd64 = 64'h0;
        case (w_reg)
            REG_OUT:  w_rd64 = r_out;
            REG_OE:   w_rd64 = r_oe;
            REG_IN:   w_rd64 = w_in;
            REG_IE:   w_rd64 = r_ie;
            REG_EDGE: w_rd64 = r_edge;
            REG_STAT: w_rd64 = r_stat;
            default:  w_rd64 = 64'h0;
        endcase
        w_rd32 = w_hi ? w_rd64[63:32] : w_rd64[31:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out   <= 64'h0;
            r_oe    <= 64'h0;
            r_ie    <= 64'h0;
            r_edge  <= 64'h0;
            r_stat  <= 64'h0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0;
            r_irq   <= 1'b0;
        end else begin
            r_out   <= w_out_d;
            r_oe    <= w_oe_d;
            r_ie    <= w_ie_d;
            r_edge  <= w_edge_d;
            r_stat  <= w_stat_d;
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_ack   <= w_acc;
            // Read data is only non-zero in the ack cycle.
            r_dat   <= w_acc ? w_rd32 : 32'h0;
            r_irq   <= |(r_stat & r_ie);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    // Reserved bits of r_out/r_oe are held at 0, giving out=0, oeb=1.
    assign gpio_out  = r_out[NUM_GPIO-1:0];
    assign gpio_oeb  = ~r_oe[NUM_GPIO-1:0];
    assign irq       = r_irq;

endmodule
